// File: rtl/retire_monitor_pkg.sv
// retire_monitor_pkg
// Shared definitions for the retire monitor: monitor state encoding and the
// default parameter values used by retire_monitor and its trace FIFO.
package retire_monitor_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int INSTR_W_DEF    = 32;
  localparam int DEPTH_DEF      = 8;
  localparam int CNT_W_DEF      = 32;
  localparam int MAX_CYCLES_DEF = 10000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_TOUT  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/retire_monitor_trace_fifo.sv
// trace_fifo
// First-word fall-through FIFO holding retired-instruction trace entries.
// The head entry is read straight out of the storage registers, so a pushed
// entry shows up on data_o the cycle after the push and holds until popped.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset (pointers only; storage is data)
//   push_i  write data_i; ignored when full unless a pop happens this cycle
//   data_i  entry to write
//   pop_i   remove the head; ignored when empty
//   valid_o FIFO is not empty
//   full_o  FIFO holds DEPTH entries
//   data_o  head entry, zero while empty
module trace_fifo
  import retire_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]   wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[IDX_W] != rd_q[IDX_W]) &&
                   (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
  assign valid_o = !empty;
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty ? '0 : mem_q[rd_q[IDX_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{IDX_W{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{IDX_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/retire_monitor.sv
// retire_monitor
// Watches the writeback retire stream, counts cycles/retires/drops, queues a
// trace of retired instructions and detects program end (halt address) or a
// run-time limit.
// Ports:
//   clk, rstn                 clock; synchronous active-high reset
//   retire_valid/pc/instr     retiring instruction this cycle
//   halt_en, halt_pc          halt-address match enable and address
//   trace_valid/ready         trace head handshake
//   trace_pc/instr/seq        trace head entry (seq = retire index from 0)
//   cycle_count               cycles spent in RUN
//   retire_count, drop_count  accepted retires, retires lost to a full FIFO
//   halted, timeout           program finished and drained / limit reached
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               retire_valid,
  input  logic [ADDR_W-1:0]  retire_pc,
  input  logic [INSTR_W-1:0] retire_instr,
  input  logic               halt_en,
  input  logic [ADDR_W-1:0]  halt_pc,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [ADDR_W-1:0]  trace_pc,
  output logic [INSTR_W-1:0] trace_instr,
  output logic [CNT_W-1:0]   trace_seq,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               halted,
  output logic               timeout
);

  localparam int ENT_W = ADDR_W + INSTR_W + CNT_W;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d, drop_q, drop_d;
  logic             fifo_valid, fifo_full;
  logic             pop, push, accept, room, halt_hit, tout_hit;
  logic [ENT_W-1:0] fifo_dout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pop      = fifo_valid && trace_ready && !rstn;
  assign accept   = (state_q == ST_RUN) && retire_valid;
  assign room     = !fifo_full || pop;
  assign push     = accept && room && !rstn;
  assign halt_hit = accept && halt_en && (retire_pc == halt_pc);
  assign tout_hit = (cycle_q == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    drop_d   = drop_q;
    if (accept) begin
      retire_d = sat_inc(retire_q);
      if (!room) drop_d = sat_inc(drop_q);
    end
    case (state_q)
      ST_RUN: begin
        // Halt wins over timeout. The timeout cycle itself is not counted,
        // so cycle_count freezes at MAX_CYCLES-1.
        if (halt_hit) begin
          state_d = ST_DRAIN;
          cycle_d = sat_inc(cycle_q);
        end else if (tout_hit) begin
          state_d = ST_TOUT;
        end else begin
          cycle_d = sat_inc(cycle_q);
        end
      end
      ST_DRAIN: if (!fifo_valid) state_d = ST_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_RUN;
      cycle_q  <= '0;
      retire_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
    end
  end

  trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rstn),
    .push_i  (push),
    .data_i  ({retire_pc, retire_instr, retire_q}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .data_o  (fifo_dout)
  );

  assign trace_valid                         = fifo_valid;
  assign {trace_pc, trace_instr, trace_seq}  = fifo_dout;
  assign cycle_count                         = cycle_q;
  assign retire_count                        = retire_q;
  assign drop_count                          = drop_q;
  assign halted                              = (state_q == ST_DONE);
  assign timeout                             = (state_q == ST_TOUT);

endmodule

// File: tb/tb_retire_monitor.sv
module tb_retire_monitor;

  localparam int DEPTH = 8;
  localparam int MAXC  = 1000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rstn, retire_valid, halt_en, trace_ready;
  logic [31:0] retire_pc, retire_instr, halt_pc;
  logic        trace_valid, halted, timeout;
  logic [31:0] trace_pc, trace_instr, trace_seq, cycle_count, retire_count, drop_count;

  retire_monitor #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .CNT_W(32), .MAX_CYCLES(MAXC)) u_dut (
    .clk(clk), .rstn(rstn), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .halt_en(halt_en), .halt_pc(halt_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_seq(trace_seq), .cycle_count(cycle_count),
    .retire_count(retire_count), .drop_count(drop_count), .halted(halted), .timeout(timeout));

  // short-timeout instance
  logic        t_rstn, t_rv, t_hen, t_ready;
  logic [31:0] t_pc, t_instr, t_hpc;
  logic        t_tvalid, t_halted, t_tout;
  logic [31:0] t_tpc, t_tinstr, t_tseq, t_cc, t_rc, t_dc;

  retire_monitor #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .CNT_W(32), .MAX_CYCLES(20)) u_tdut (
    .clk(clk), .rstn(t_rstn), .retire_valid(t_rv), .retire_pc(t_pc),
    .retire_instr(t_instr), .halt_en(t_hen), .halt_pc(t_hpc),
    .trace_valid(t_tvalid), .trace_ready(t_ready), .trace_pc(t_tpc),
    .trace_instr(t_tinstr), .trace_seq(t_tseq), .cycle_count(t_cc),
    .retire_count(t_rc), .drop_count(t_dc), .halted(t_halted), .timeout(t_tout));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_reset();
    rstn = 1'b1; retire_valid = 1'b0; trace_ready = 1'b0; halt_en = 1'b0;
    tick();
    rstn = 1'b0;
  endtask

  task automatic t_reset();
    t_rstn = 1'b1; t_rv = 1'b0; t_ready = 1'b0; t_hen = 1'b0;
    tick();
    t_rstn = 1'b0;
  endtask

  // ---------------- reference model: queue of trace entries ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] seq;
  } ent_t;
  ent_t mq[$];
  int   m_st;   // 0 running, 1 draining, 2 done, 3 timed out
  int   m_cc, m_rc, m_dc;

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] pc,
                            input logic [31:0] instr, input logic hen,
                            input logic [31:0] hpc, input logic rdy);
    int  had;
    bit  hit;
    if (rst) begin
      mq.delete(); m_st = 0; m_cc = 0; m_rc = 0; m_dc = 0;
      return;
    end
    had = mq.size();
    if (had > 0 && rdy) void'(mq.pop_front());
    if (m_st == 0) begin
      hit = rv && hen && (pc == hpc);
      if (rv) begin
        if (mq.size() < DEPTH) mq.push_back('{pc, instr, m_rc});
        else m_dc++;
        m_rc++;
      end
      if (hit) begin m_st = 1; m_cc++; end
      else if (m_cc == MAXC - 1) m_st = 3;
      else m_cc++;
    end else if (m_st == 1) begin
      if (had == 0) m_st = 2;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] pc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eseq;
    logic [31:0] erc;
    logic [31:0] edc;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int npop, last_pop_n, halt_n, tn;
    rstn = 1'b1; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
    halt_en = 1'b0; halt_pc = '0; trace_ready = 1'b0;
    t_rstn = 1'b1; t_rv = 1'b0; t_pc = '0; t_instr = '0; t_hen = 1'b0; t_hpc = '0; t_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 32'd0, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'd0, 32'd1, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 32'h100, 32'd0, 32'd2, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h104, 32'd1, 32'd2, 32'd0};
    tbl[4] = '{1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h104, 32'd1, 32'd2, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 32'd2, 32'd3, 32'd0};
    tbl[6] = '{1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 32'd0, 32'd3, 32'd0};
    tbl[7] = '{1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 32'h10C, 32'd3, 32'd4, 32'd0};
    tbl[8] = '{1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h000, 32'd0, 32'd0, 32'd0};
    tbl[9] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 32'd0, 32'd1, 32'd0};

    for (int i = 0; i < 10; i++) begin
      rstn = tbl[i].rst; retire_valid = tbl[i].rv; retire_pc = tbl[i].pc;
      retire_instr = tbl[i].pc ^ 32'hA5A5_0000; trace_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), trace_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), trace_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), trace_instr, tbl[i].epc ^ 32'hA5A5_0000);
        chk($sformatf("tbl%0d_seq", i), trace_seq, tbl[i].eseq);
      end
      chk($sformatf("tbl%0d_rc", i), retire_count, tbl[i].erc);
      chk($sformatf("tbl%0d_dc", i), drop_count, tbl[i].edc);
      if (tbl[i].rst) begin
        chk($sformatf("tbl%0d_cc", i), cycle_count, 0);
        chk($sformatf("tbl%0d_halted", i), halted, 0);
        chk($sformatf("tbl%0d_timeout", i), timeout, 0);
      end
    end
    rstn = 1'b0;

    // ---------------- basic flow to halt ----------------
    main_reset();
    halt_en = 1'b1; halt_pc = 32'h78; trace_ready = 1'b1;
    npop = 0; last_pop_n = -1; halt_n = -1;
    for (int n = 0; n < 80 && halt_n < 0; n++) begin
      retire_valid = (n < 31); retire_pc = 4 * n; retire_instr = 32'h13 + n;
      if (trace_valid) begin
        chk("flow_pc", trace_pc, 4 * npop);
        chk("flow_seq", trace_seq, npop);
        npop++; last_pop_n = n;
      end
      tick();
      if (halted && halt_n < 0) halt_n = n;
    end
    chk("flow_pops", npop, 31);
    chk("flow_rc", retire_count, 31);
    chk("flow_dc", drop_count, 0);
    chk("flow_halt_time", halt_n, last_pop_n + 1);
    chk("flow_no_timeout", timeout, 0);
    retire_valid = 1'b0; halt_en = 1'b0;

    // ---------------- overflow, then full with simultaneous pop ----------------
    main_reset();
    trace_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      retire_valid = 1'b1; retire_pc = 32'h1000 + 4 * k; retire_instr = k;
      tick();
    end
    retire_valid = 1'b0;
    chk("ovf_rc", retire_count, 12);
    chk("ovf_dc", drop_count, 4);
    chk("ovf_head_pc", trace_pc, 32'h1000);
    chk("ovf_head_seq", trace_seq, 0);
    retire_valid = 1'b1; retire_pc = 32'h2000; trace_ready = 1'b1;
    tick();
    retire_valid = 1'b0;
    chk("full_pop_dc", drop_count, 4);
    chk("full_pop_rc", retire_count, 13);
    chk("full_pop_head", trace_pc, 32'h1004);
    npop = 0;
    for (int n = 0; n < 20; n++) begin
      if (trace_valid) begin
        if (npop < 8) begin
          chk("full_drain_pc", trace_pc, (npop < 7) ? 32'h1004 + 4 * npop : 32'h2000);
          chk("full_drain_seq", trace_seq, (npop < 7) ? npop + 1 : 12);
        end
        npop++;
      end
      tick();
    end
    chk("full_occupancy", npop, 8);
    trace_ready = 1'b0;

    // ---------------- reset while draining ----------------
    main_reset();
    halt_en = 1'b1; halt_pc = 32'h3010; trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      retire_valid = 1'b1; retire_pc = 32'h3000 + 4 * k; tick();
    end
    retire_valid = 1'b0; tick();
    chk("drain_valid", trace_valid, 1);
    chk("drain_not_halted", halted, 0);
    chk("drain_rc", retire_count, 5);
    rstn = 1'b1; retire_valid = 1'b1; retire_pc = 32'h3010; trace_ready = 1'b1;
    tick();
    rstn = 1'b0; halt_en = 1'b0; trace_ready = 1'b0;
    chk("rst_valid", trace_valid, 0);
    chk("rst_rc", retire_count, 0);
    chk("rst_dc", drop_count, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_halted", halted, 0);
    retire_pc = 32'h4000; retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
    chk("rst_next_valid", trace_valid, 1);
    chk("rst_next_pc", trace_pc, 32'h4000);
    chk("rst_next_seq", trace_seq, 0);
    chk("rst_next_rc", retire_count, 1);

    // ---------------- timeout ----------------
    t_reset();
    tn = -1;
    for (int n = 1; n <= 40 && tn < 0; n++) begin
      t_rv = (n <= 3); t_pc = 32'h600 + 4 * n; t_instr = n;
      tick();
      if (n == 19) begin
        chk("tout_early", t_tout, 0);
        chk("tout_cc19", t_cc, 19);
      end
      if (t_tout) tn = n;
    end
    chk("tout_time", tn, 20);
    chk("tout_cc_frozen", t_cc, 19);
    t_rv = 1'b1; t_pc = 32'h700;
    for (int n = 0; n < 4; n++) tick();
    t_rv = 1'b0;
    chk("tout_ignore_rc", t_rc, 3);
    chk("tout_ignore_dc", t_dc, 0);
    chk("tout_cc_still", t_cc, 19);
    t_ready = 1'b1; npop = 0;
    for (int n = 0; n < 10; n++) begin
      if (t_tvalid) begin
        chk("tout_drain_seq", t_tseq, npop);
        chk("tout_drain_pc", t_tpc, 32'h604 + 4 * npop);
        npop++;
      end
      tick();
    end
    chk("tout_drain_count", npop, 3);
    chk("tout_stays", t_tout, 1);
    chk("tout_not_halted", t_halted, 0);

    // ---------------- halt and timeout in the same cycle ----------------
    t_reset();
    t_hen = 1'b1; t_hpc = 32'h50; t_ready = 1'b0;
    for (int n = 1; n <= 19; n++) tick();
    chk("both_pre_tout", t_tout, 0);
    t_rv = 1'b1; t_pc = 32'h50;
    tick();
    t_rv = 1'b0;
    chk("both_tout", t_tout, 0);
    chk("both_halted_early", t_halted, 0);
    chk("both_valid", t_tvalid, 1);
    chk("both_rc", t_rc, 1);
    t_ready = 1'b1;
    tick();
    tick();
    chk("both_halted", t_halted, 1);
    chk("both_tout_final", t_tout, 0);

    // ---------------- randomized against the model ----------------
    main_reset();
    model_step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 500; c++) begin
      rstn         = ($urandom_range(0, 59) == 0);
      retire_valid = ($urandom_range(0, 2) != 0);
      retire_pc    = $urandom_range(0, 15) * 4;
      retire_instr = $urandom;
      halt_en      = ($urandom_range(0, 3) == 0);
      halt_pc      = $urandom_range(0, 15) * 4;
      trace_ready  = ($urandom_range(0, 2) == 0);
      tick();
      model_step(rstn, retire_valid, retire_pc, retire_instr, halt_en, halt_pc, trace_ready);
      chk("rnd_valid", trace_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_pc", trace_pc, mq[0].pc);
        chk("rnd_instr", trace_instr, mq[0].instr);
        chk("rnd_seq", trace_seq, mq[0].seq);
      end
      chk("rnd_rc", retire_count, m_rc);
      chk("rnd_dc", drop_count, m_dc);
      chk("rnd_cc", cycle_count, m_cc);
      chk("rnd_halted", halted, m_st == 2);
      chk("rnd_timeout", timeout, m_st == 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
